idex_stage_reg: RTL and testbench

Parametrised ID/EX pipeline register for the pipelined RISC-V core, sitting between the decode stage (register file, immediate generator, control unit) and the execute stage (ALU, forwarding muxes). It replaces the free-running ID/EX register with four additions:

- a per-entry valid bit;
- stall and flush inputs;
- bubble insertion, with a saturating count of inserted bubbles;
- optionally, built-in load-use hazard detection that inserts its own bubble.

---
 rtl/idex_stage_reg_if.sv | 49 ++++
 rtl/idex_stage_reg.sv | 163 ++++++++++++++++
 tb/tb_idex_stage_reg.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/idex_stage_reg_if.sv
// ID/EX pipeline-register bus: decode-side inputs, execute-side outputs, hazard and bubble status.
// The decode/control side uses the master modport and the stage register uses the slave modport.
interface idex_stage_reg_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 9,
    parameter int FUNCT_W    = 4,
    parameter int CNT_W      = 16
);
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [CTRL_W-1:0]     id_ctrl;
    logic [XLEN-1:0]       id_pc;
    logic [XLEN-1:0]       id_rd1;
    logic [XLEN-1:0]       id_rd2;
    logic [XLEN-1:0]       id_imm;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [FUNCT_W-1:0]    id_funct;

    logic                  ex_valid;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_rd1;
    logic [XLEN-1:0]       ex_rd2;
    logic [XLEN-1:0]       ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [FUNCT_W-1:0]    ex_funct;
    logic                  hazard_stall;
    logic [CNT_W-1:0]      bubble_count;

    modport master (
        output stall, flush, id_valid, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_funct,
        input  ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct, hazard_stall, bubble_count
    );

    modport slave (
        input  stall, flush, id_valid, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_funct,
        output ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct, hazard_stall, bubble_count
    );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with valid bit, stall/flush, bubble insertion and a saturating bubble counter.
// Optional load-use hazard detection is enabled by defining the macro IDEX_LOAD_USE_EN.
module idex_stage_reg #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 9,
    parameter int FUNCT_W    = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    idex_stage_reg_if.slave   bus
);

    localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = {REG_ADDR_W{1'b0}};
    localparam logic [CTRL_W-1:0]     CTRL_ZERO  = {CTRL_W{1'b0}};
    localparam int                    MEMREAD_BIT = 3;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } act_e;

    logic                  valid_q, valid_d;
    logic [CTRL_W-1:0]     ctrl_q,  ctrl_d;
    logic [XLEN-1:0]       pc_q,    pc_d;
    logic [XLEN-1:0]       rd1_q,   rd1_d;
    logic [XLEN-1:0]       rd2_q,   rd2_d;
    logic [XLEN-1:0]       imm_q,   imm_d;
    logic [REG_ADDR_W-1:0] rs1_q,   rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q,   rs2_d;
    logic [REG_ADDR_W-1:0] rd_q,    rd_d;
    logic [FUNCT_W-1:0]    funct_q, funct_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic                  hazard_s;
    logic                  count_inc_s;
    act_e                  act_s;

    // Load-use detection: a load in EX whose destination feeds the instruction now in ID.
    always_comb begin
`ifdef IDEX_LOAD_USE_EN
        hazard_s = valid_q & ctrl_q[MEMREAD_BIT] & (rd_q != REG_ZERO) & bus.id_valid &
                   ((rd_q == bus.id_rs1) | (rd_q == bus.id_rs2));
`else
        hazard_s = 1'b0;
`endif
    end

    // One action per edge: flush beats stall, stall beats the internal bubble, which beats a load.
    always_comb begin
        act_s       = ACT_LOAD;
        count_inc_s = 1'b0;
        if (bus.flush) begin
            act_s       = ACT_BUBBLE;
            count_inc_s = 1'b1;
        end else if (bus.stall) begin
            act_s       = ACT_HOLD;
            count_inc_s = 1'b0;
        end else if (hazard_s) begin
            act_s       = ACT_BUBBLE;
            count_inc_s = 1'b1;
        end else begin
            act_s       = ACT_LOAD;
            count_inc_s = ~bus.id_valid;
        end
    end

    // Next-state for the EX-side entry; a bubble clears only valid and control.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        funct_d = funct_q;
        case (act_s)
            ACT_LOAD: begin
                valid_d = bus.id_valid;
                ctrl_d  = bus.id_valid ? bus.id_ctrl : CTRL_ZERO;
                pc_d    = bus.id_pc;
                rd1_d   = bus.id_rd1;
                rd2_d   = bus.id_rd2;
                imm_d   = bus.id_imm;
                rs1_d   = bus.id_rs1;
                rs2_d   = bus.id_rs2;
                rd_d    = bus.id_rd;
                funct_d = bus.id_funct;
            end
            ACT_BUBBLE: begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_ZERO;
            end
            ACT_HOLD: begin
                valid_d = valid_q;
                ctrl_d  = ctrl_q;
            end
            default: begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_ZERO;
            end
        endcase
    end

    // Bubble counter saturates rather than wrapping.
    always_comb begin
        if (count_inc_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // EX-side state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_ZERO;
            pc_q    <= {XLEN{1'b0}};
            rd1_q   <= {XLEN{1'b0}};
            rd2_q   <= {XLEN{1'b0}};
            imm_q   <= {XLEN{1'b0}};
            rs1_q   <= REG_ZERO;
            rs2_q   <= REG_ZERO;
            rd_q    <= REG_ZERO;
            funct_q <= {FUNCT_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_valid     = valid_q;
    assign bus.ex_ctrl      = ctrl_q;
    assign bus.ex_pc        = pc_q;
    assign bus.ex_rd1       = rd1_q;
    assign bus.ex_rd2       = rd2_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rs1       = rs1_q;
    assign bus.ex_rs2       = rs2_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_funct     = funct_q;
    assign bus.hazard_stall = hazard_s;
    assign bus.bubble_count = cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Scoreboard bench for idex_stage_reg: directed vectors push expected EX state, a monitor checks each edge.
// A second instance with a 2-bit counter exercises saturation; load-use checks follow IDEX_LOAD_USE_EN.
module tb_idex_stage_reg;

    logic clock;
    logic reset;
    logic sat_flush;
    int   errors;
    int   checks;

    typedef struct {
        logic        valid;
        logic [8:0]  ctrl;
        logic [63:0] pc;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  funct;
        logic [15:0] cnt;
        logic [1:0]  sat_cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;

    idex_stage_reg_if #(.CNT_W(16)) bus ();
    idex_stage_reg_if #(.CNT_W(2))  sbus ();

    idex_stage_reg #(.CNT_W(16)) u_dut (.clock(clock), .reset(reset), .bus(bus));
    idex_stage_reg #(.CNT_W(2))  u_sat (.clock(clock), .reset(reset), .bus(sbus));

    // Saturation instance always loads a valid, control-free entry unless told to flush.
    assign sbus.stall    = 1'b0;
    assign sbus.flush    = sat_flush;
    assign sbus.id_valid = 1'b1;
    assign sbus.id_ctrl  = 9'h000;
    assign sbus.id_pc    = bus.id_pc;
    assign sbus.id_rd1   = bus.id_rd1;
    assign sbus.id_rd2   = bus.id_rd2;
    assign sbus.id_imm   = bus.id_imm;
    assign sbus.id_rs1   = bus.id_rs1;
    assign sbus.id_rs2   = bus.id_rs2;
    assign sbus.id_rd    = bus.id_rd;
    assign sbus.id_funct = bus.id_funct;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m = '{valid: 1'b0, ctrl: 9'h000, pc: 64'h0, rd1: 64'h0, rd2: 64'h0, imm: 64'h0,
              rs1: 5'd0, rs2: 5'd0, rd: 5'd0, funct: 4'h0, cnt: 16'h0, sat_cnt: 2'd0};
    endtask

    // Drive one vector at the falling edge, check hazard_stall, then queue the state expected after the next rise.
    task automatic drv(input logic st, input logic fl, input logic sfl, input logic v,
                       input logic [8:0] ctrl, input logic [63:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        logic haz;
        @(negedge clock);
        bus.stall    = st;
        bus.flush    = fl;
        sat_flush    = sfl;
        bus.id_valid = v;
        bus.id_ctrl  = ctrl;
        bus.id_pc    = pc;
        bus.id_rd1   = pc ^ 64'hA5A5_0000_0000_1111;
        bus.id_rd2   = pc + 64'd7;
        bus.id_imm   = ~pc;
        bus.id_rs1   = rs1;
        bus.id_rs2   = rs2;
        bus.id_rd    = rd;
        bus.id_funct = pc[5:2];
`ifdef IDEX_LOAD_USE_EN
        haz = m.valid & m.ctrl[3] & (m.rd != 5'd0) & v & ((m.rd == rs1) | (m.rd == rs2));
`else
        haz = 1'b0;
`endif
        #1;
        chk("hazard_stall", {63'd0, bus.hazard_stall}, {63'd0, haz});
        if (fl || (!st && haz)) begin
            m.valid = 1'b0;
            m.ctrl  = 9'h000;
            if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        end else if (!st) begin
            m.valid = v;
            m.ctrl  = v ? ctrl : 9'h000;
            m.pc    = bus.id_pc;
            m.rd1   = bus.id_rd1;
            m.rd2   = bus.id_rd2;
            m.imm   = bus.id_imm;
            m.rs1   = rs1;
            m.rs2   = rs2;
            m.rd    = rd;
            m.funct = bus.id_funct;
            if (!v && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        end
        if (sfl && m.sat_cnt != 2'd3) m.sat_cnt = m.sat_cnt + 2'd1;
        exp_q.push_back(m);
    endtask

    // Monitor: one expected entry per rising edge while the scoreboard holds any.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_valid", {63'd0, bus.ex_valid}, {63'd0, e.valid});
                chk("ex_ctrl", {55'd0, bus.ex_ctrl}, {55'd0, e.ctrl});
                chk("ex_pc", bus.ex_pc, e.pc);
                chk("ex_rd", {59'd0, bus.ex_rd}, {59'd0, e.rd});
                chk("ex_data", bus.ex_rd1 ^ bus.ex_rd2 ^ bus.ex_imm ^
                    {49'd0, bus.ex_rs1, bus.ex_rs2, bus.ex_funct, 1'b0},
                    e.rd1 ^ e.rd2 ^ e.imm ^ {49'd0, e.rs1, e.rs2, e.funct, 1'b0});
                chk("ex_rd1", bus.ex_rd1, e.rd1);
                chk("bubble_count", {48'd0, bus.bubble_count}, {48'd0, e.cnt});
                chk("sat_bubble_count", {62'd0, sbus.bubble_count}, {62'd0, e.sat_cnt});
            end
        end
    end

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        sat_flush = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.id_valid = 1'b1;
        bus.id_ctrl  = 9'h1FF;
        bus.id_pc    = {64{1'b1}};
        bus.id_rd1   = {64{1'b1}};
        bus.id_rd2   = {64{1'b1}};
        bus.id_imm   = {64{1'b1}};
        bus.id_rs1   = 5'h1F;
        bus.id_rs2   = 5'h1F;
        bus.id_rd    = 5'h1F;
        bus.id_funct = 4'hF;
        model_reset();
        #2;
        chk("reset_valid_ctrl", {54'd0, bus.ex_valid, bus.ex_ctrl}, 64'd0);
        chk("reset_datapath", bus.ex_pc | bus.ex_rd1 | bus.ex_rd2 | bus.ex_imm, 64'd0);
        chk("reset_indices", {45'd0, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct}, 64'd0);
        chk("reset_count", {48'd0, bus.bubble_count}, 64'd0);
        chk("reset_hazard", {63'd0, bus.hazard_stall}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Basic load, then three stalls with changing inputs, then flush overriding stall.
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h0A5, 64'h100, 5'd1, 5'd2, 5'd5);
        drv(1'b1, 1'b0, 1'b0, 1'b1, 9'h003, 64'h200, 5'd3, 5'd4, 5'd6);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 9'h1FF, 64'h300, 5'd7, 5'd8, 5'd9);
        drv(1'b1, 1'b0, 1'b0, 1'b1, 9'h011, 64'h400, 5'd5, 5'd5, 5'd10);
        drv(1'b1, 1'b1, 1'b0, 1'b1, 9'h021, 64'h500, 5'd1, 5'd1, 5'd11);
        // Invalid slot must not leak control.
        drv(1'b0, 1'b0, 1'b0, 1'b0, 9'h1FF, 64'h600, 5'd2, 5'd3, 5'd12);
        // ld x5 followed by add using x5, retried the cycle after.
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h00B, 64'h700, 5'd1, 5'd0, 5'd5);
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h101, 64'h704, 5'd3, 5'd5, 5'd6);
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h101, 64'h704, 5'd3, 5'd5, 5'd6);
        // ld x0 followed by a reader of x0 never hazards.
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h00B, 64'h800, 5'd1, 5'd0, 5'd0);
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h101, 64'h804, 5'd0, 5'd0, 5'd7);
        // Hazard is still reported under stall and under flush; those actions take priority.
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h00B, 64'h900, 5'd1, 5'd0, 5'd9);
        drv(1'b1, 1'b0, 1'b0, 1'b1, 9'h101, 64'h904, 5'd9, 5'd2, 5'd3);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 9'h101, 64'h904, 5'd9, 5'd2, 5'd3);
        // Five consecutive flushes on the 2-bit counter: 1, 2, 3, 3, 3.
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b0, 1'b1, 1'b1, 9'h041, 64'hA00 + 64'(i * 4), 5'd1, 5'd2, 5'd3);
        end
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h041, 64'hB00, 5'd1, 5'd2, 5'd3);

        // Mid-operation asynchronous reset clears everything before any edge.
        @(negedge clock);
        while (exp_q.size() > 0) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midreset_valid_ctrl", {54'd0, bus.ex_valid, bus.ex_ctrl}, 64'd0);
        chk("midreset_pc", bus.ex_pc, 64'd0);
        chk("midreset_count", {46'd0, sbus.bubble_count, bus.bubble_count}, 64'd0);
        #1;
        reset = 1'b1;
        model_reset();
        drv(1'b0, 1'b0, 1'b0, 1'b1, 9'h0A5, 64'hC00, 5'd4, 5'd5, 5'd6);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 9'h0A5, 64'hC04, 5'd4, 5'd5, 5'd6);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #3;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
